// File: rtl/serial_subtractor_if.sv
// Handshake/operand/result bundle for serial_subtractor.
// Optional macro SERIAL_SUBTRACTOR_ADD_MODE_EN adds the 'op' select signal.
interface serial_subtractor_if #(
    parameter int unsigned W = 8
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    logic         op;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    logic         zero;

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    modport master (
        output start, a, b, op,
        input  busy, done, diff, borrow, ovf, zero
    );
    modport slave (
        input  start, a, b, op,
        output busy, done, diff, borrow, ovf, zero
    );
`else
    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, ovf, zero
    );
    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, ovf, zero
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b over W cycles with one borrow FF.
// Optional macro SERIAL_SUBTRACTOR_ADD_MODE_EN: adds op input (1 = subtract, 0 = add);
// in add mode 'borrow' reports carry-out and ovf uses the addition rule.
module serial_subtractor #(
    parameter int unsigned W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int unsigned   CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state_q;
    logic [W-1:0]  sa_q;
    logic [W-1:0]  sb_q;
    logic [W-1:0]  res_q;
    logic [W-1:0]  res_d;
    logic [CW-1:0] cnt_q;
    logic          bff_q;
    logic          bo_d;
    logic          d_d;
    logic          ovf_d;
    logic          asign_q;
    logic          bsign_q;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    logic          op_q;
`endif
    logic          busy_q;
    logic          done_q;
    logic [W-1:0]  diff_q;
    logic          borrow_q;
    logic          ovf_q;
    logic          zero_q;

    // One-bit full subtract (or add) stage and the next partial result
    always_comb begin
        d_d   = sa_q[0] ^ sb_q[0] ^ bff_q;
        bo_d  = (~sa_q[0] & sb_q[0]) | (~sa_q[0] & bff_q) | (sb_q[0] & bff_q);
        res_d = {d_d, res_q[W-1:1]};
        ovf_d = (asign_q != bsign_q) && (res_d[W-1] != asign_q);
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        if (!op_q) begin
            bo_d  = (sa_q[0] & sb_q[0]) | (sa_q[0] & bff_q) | (sb_q[0] & bff_q);
            ovf_d = (asign_q == bsign_q) && (res_d[W-1] != asign_q);
        end
`endif
    end

    // Control FSM, operand shifters and registered result/flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bff_q    <= 1'b0;
            asign_q  <= 1'b0;
            bsign_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
            op_q     <= 1'b1;
`endif
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sa_q    <= bus.a;
                        sb_q    <= bus.b;
                        res_q   <= '0;
                        bff_q   <= 1'b0;
                        cnt_q   <= '0;
                        asign_q <= bus.a[W-1];
                        bsign_q <= bus.b[W-1];
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
                        op_q    <= bus.op;
`endif
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    bff_q <= bo_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        diff_q   <= res_d;
                        borrow_q <= bo_d;
                        zero_q   <= (res_d == '0);
                        ovf_q    <= ovf_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + short random bench for serial_subtractor with a result scoreboard.
// Honours SERIAL_SUBTRACTOR_ADD_MODE_EN when defined.
module tb_serial_subtractor;
    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    logic [W-1:0] last_diff;

    serial_subtractor_if #(.W(W)) ifc ();

    serial_subtractor #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: integer arithmetic, not bit-serial
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit op);
        exp_t e;
        int   sv;
        int   uv;
        if (op) begin
            uv = int'(a) - int'(b);
            sv = int'($signed(a)) - int'($signed(b));
            e.borrow = (a < b);
        end else begin
            uv = int'(a) + int'(b);
            sv = int'($signed(a)) + int'($signed(b));
            e.borrow = (uv > 255);
        end
        e.diff = uv[W-1:0];
        e.ovf  = (sv > 127) || (sv < -128);
        e.zero = (e.diff == 0);
        return e;
    endfunction

    // Drive start for one cycle; returns just after the capture edge
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit op);
        ifc.start = 1'b1;
        ifc.a     = a;
        ifc.b     = b;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        ifc.op    = op;
`endif
        sb_q.push_back(model(a, b, op));
        tick();
        ifc.start = 1'b0;
        check("busy_after_start", ifc.busy, 1);
        check("done_low_after_start", ifc.done, 0);
    endtask

    // Wait (bounded) for done, then pop and compare the scoreboard entry
    task automatic wait_done(input int exp_lat);
        int   cyc  = 0;
        bit   seen = 0;
        exp_t e;
        while (!seen && cyc < int'(W) + 4) begin
            tick();
            cyc++;
            if (ifc.done === 1'b1) seen = 1;
            else check("busy_during_op", ifc.busy, 1);
        end
        check("done_seen", seen, 1);
        if (exp_lat > 0) check("latency", cyc, exp_lat);
        check("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("diff", ifc.diff, e.diff);
            check("borrow", ifc.borrow, e.borrow);
            check("ovf", ifc.ovf, e.ovf);
            check("zero", ifc.zero, e.zero);
            check("busy_at_done", ifc.busy, 0);
            last_diff = e.diff;
        end
    endtask

    initial begin
        int dcount;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst_n     = 1'b0;
        ifc.start = 1'b0;
        ifc.a     = '0;
        ifc.b     = '0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        ifc.op    = 1'b1;
`endif
        last_diff = '0;
        #12;
        check("reset_outputs", {ifc.busy, ifc.done, ifc.borrow, ifc.ovf, ifc.zero, ifc.diff}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic subtract with exact latency and one-cycle done pulse
        start_op(8'h05, 8'h03, 1'b1);
        wait_done(W);
        tick();
        check("done_one_cycle", ifc.done, 0);
        check("diff_hold_idle", ifc.diff, 8'h02);

        start_op(8'h03, 8'h05, 1'b1);
        wait_done(W);
        start_op(8'h80, 8'h01, 1'b1);
        wait_done(W);
        start_op(8'h7F, 8'hFF, 1'b1);
        wait_done(W);
        start_op(8'h5A, 8'h5A, 1'b1);
        wait_done(W);
        // Back-to-back start in the done cycle
        start_op(8'hFF, 8'h00, 1'b1);
        wait_done(W);

        // Start while busy is ignored; results hold during the operation
        tick();
        start_op(8'h10, 8'h01, 1'b1);
        tick();
        tick();
        check("diff_hold_busy", ifc.diff, last_diff);
        ifc.start = 1'b1;
        ifc.a     = 8'h00;
        ifc.b     = 8'h00;
        tick();
        ifc.start = 1'b0;
        ifc.a     = 8'hAA;
        ifc.b     = 8'h55;
        wait_done(W - 3);

        // Asynchronous reset mid-operation aborts without a done pulse
        tick();
        start_op(8'h33, 8'h11, 1'b1);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("reset_midop_outputs", {ifc.busy, ifc.done, ifc.borrow, ifc.ovf, ifc.zero, ifc.diff}, 0);
        sb_q.delete();
        tick();
        rst_n = 1'b1;
        dcount = 0;
        repeat (W + 3) begin
            tick();
            if (ifc.done === 1'b1) dcount++;
        end
        check("no_done_after_abort", dcount, 0);
        check("idle_after_abort", ifc.busy, 0);

        // Short random sweep
        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            start_op(ra, rb, 1'b1);
            wait_done(W);
        end

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(W);
        start_op(8'h7F, 8'h01, 1'b0);
        wait_done(W);
        start_op(8'h80, 8'h80, 1'b0);
        wait_done(W);
        start_op(8'h05, 8'h03, 1'b1);
        wait_done(W);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor computing diff = a - b over W clock cycles using one borrow flip-flop.
- Serves as the sequential, area-minimal inverse of the combinational ripple adder in the adder_subs arithmetic set.
- Operands are captured on a start handshake; result and flags are registered and held until the next operation completes.

Parameters:
- W, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while busy=0.
- a  input  W  minuend; captured on accepted start.
- b  input  W  subtrahend; captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result registers update.
- diff  output  W  registered result a - b, mod 2^W.
- borrow  output  1  final borrow-out; 1 iff a < b as unsigned values.
- ovf  output  1  signed two's-complement overflow of a - b.
- zero  output  1  1 iff diff == 0.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, diff=0, borrow=0, ovf=0, zero=0, operand shift registers, bit counter and borrow FF cleared. Reset mid-operation aborts the operation with no done pulse.
- FSM has two states, IDLE and SHIFT.
- IDLE: busy=0. If start=1 at edge k: load sa<=a, sb<=b, bff<=0, cnt<=0, sign snapshot a[W-1], b[W-1]; go to SHIFT.
- SHIFT: busy=1. Each edge computes d = sa[0]^sb[0]^bff and bo = (~sa[0]&sb[0]) | (~sa[0]&bff) | (sb[0]&bff).
  - Shift d into the MSB of the partial-result register; shift sa and sb right by 1; set bff<=bo; cnt<=cnt+1.
- Completion: on the edge where cnt==W-1 (edge k+W):
  - diff<=final partial result; borrow<=bo; zero<=(final result==0).
  - ovf<=(a_sign != b_sign) && (result MSB != a_sign).
  - done<=1 for exactly one cycle; state<=IDLE.
- Latency: start sampled at edge k, done high and results valid after edge k+W. Throughput is one operation per W+1 cycles; start may be re-asserted in the same cycle done is high.
- start while busy=1 is ignored and has no side effects. a and b may change freely after capture.
- diff, borrow, ovf and zero hold their last values between completions; they change only at a completion edge or at reset.
- Widths: cnt is ceil(log2(W)) bits. No carry-in input; bff always starts at 0.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_ADD_MODE_EN.
- Defined:
  - Extra input port op (1 bit), captured at start. op=1 subtracts (behaviour above); op=0 adds.
  - In add mode: s=a0^b0^c and c_out=majority(a0,b0,c). The borrow output reports carry-out, and ovf = (a_sign==b_sign) && (result MSB != a_sign).
- Undefined: no op port; block always subtracts.

Test Plan:
- W=8, a=0x05, b=0x03, start at edge 0 -> busy=1 at edges 1..7; done pulse after edge 8; diff=0x02, borrow=0, ovf=0, zero=0.
- a=0x03, b=0x05 -> diff=0xFE, borrow=1, ovf=0, zero=0.
- a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1. Also a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
- a=0x5A, b=0x5A -> diff=0x00, zero=1, borrow=0. Then back-to-back start in the done cycle with a=0xFF, b=0x00 -> diff=0xFF after 8 more edges.
- Start a=0x10, b=0x01; pulse start again at edge 3 with a=0x00, b=0x00 -> ignored, diff=0x0F. Separately, drop rst_n at edge 4 -> all outputs 0 immediately, no done pulse.
- With SERIAL_SUBTRACTOR_ADD_MODE_EN and op=0: a=0xFF, b=0x01 -> diff=0x00, borrow(carry)=1, zero=1, ovf=0. Then a=0x7F, b=0x01 -> diff=0x80, ovf=1.
